alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequential arbiter that shares one combinational 32-bit ALU among four requesters. It accepts at most one operation at a time through per-requester valid/ready handshakes and selects among contending requesters by round-robin. The chosen operands are registered, and the ALU result and flags are returned on a shared response bus tagged with the granted requester. It sits between the four user ports and the single ALU instance.

## Interface
- `DATA_WIDTH`, 32, operand/result width.
- `NUM_REQ`, 4, number of requesters. Only 4 is supported; the grant ID is 2 bits.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 4: bit i means requester i has an operation pending.
- `req_ready` out 4: one-hot. Bit i means requester i's operation is accepted this cycle.
- `req_a` in 128: packed A operands. Requester i is at [32i+31:32i].
- `req_b` in 128: packed B operands, same packing as `req_a`.
- `req_op` in 12: packed 3-bit ALUop codes. Requester i is at [3i+2:3i].
- `rsp_valid` out 4: one-hot. Bit g means the response for requester g is valid.
- `rsp_ready` in 4: bit i means requester i accepts its response.
- `rsp_result` out 32: registered ALU Result.
- `rsp_zero`, `rsp_overflow`, `rsp_carryout` out 1 each: registered ALU flags.
- `grant_id` out 2: requester currently being served.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If `req_valid` is nonzero, choose the winner g by round-robin, starting from `last_grant + 1` mod 4.
  - Assert `req_ready[g]` combinationally in that same cycle.
  - Latch `req_a[g]`, `req_b[g]` and `req_op[g]` into operand registers. Update `grant_id` and `last_grant` to g. Go to EXEC.
  - If `req_valid` is zero, stay in IDLE.
- EXEC:
  - The ALU evaluates the latched operands.
  - Capture `Result`, `Zero`, `Overflow` and `CarryOut` into the response registers. Go to RESP.
- RESP:
  - Hold `rsp_valid[grant_id]` high with stable data.
  - When `rsp_ready[grant_id]` is high, go to IDLE. `rsp_ready` bits of other requesters are ignored.
- `req_ready` is 0 outside IDLE. Requesters must hold `req_valid` and their operands stable until they see `req_ready`.
- A `req_valid` that drops before it is granted is simply not served. No error is raised.
- ALUop codes:
  - 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT.
  - Any other code returns a result of 0 with `rsp_zero` = 1. Flags are whatever the ALU produces; the arbiter does not filter them.
- A requester whose response is pending may also have a new request pending. The new request is arbitrated normally once the FSM returns to IDLE.

## Timing
- Reset values: FSM = IDLE, `last_grant` = 3 (so requester 0 wins first), `grant_id` = 0.
- All outputs reset to 0: `req_ready`, `rsp_valid`, `rsp_result`, all three flags, `busy`.
- Latency: accept in cycle T, `rsp_valid` high in T+2.
- Best-case throughput: one operation per 3 cycles, when `rsp_ready` is held high.
- Back-to-back: `rsp_ready` in cycle T+2 returns the FSM to IDLE at T+3, and the next grant can happen in T+3.
- `rsp_*` outputs are registered. `req_ready` is combinational from `req_valid` and state.
- Reset mid-operation:
  - Asserting `rst` in EXEC or RESP drops the in-flight operation.
  - `rsp_valid` falls to 0 immediately (asynchronous reset).
- Wrap-around: after g = 3 the search starts at requester 0.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority 0 > 1 > 2 > 3. `last_grant` is still updated but ignored for selection.
  - Undefined (default): round-robin as described above.
  - Interface and latency are identical in both modes.

## Structure
- Shared package `alu_arb_pkg`:
  - ALUop encodings (AND/OR/ADD/SUB/SLT).
  - FSM state encoding (IDLE/EXEC/RESP, 2 bits).
  - `NUM_REQ`, `ID_W` = 2.
- One natural sub-module, `alu_rr_pick`: combinational round-robin/fixed-priority picker.
  - Inputs: `req_valid`, `last_grant`.
  - Outputs: one-hot grant and 2-bit ID.
- The shared ALU is instantiated once, with the team's standard port names A, B, ALUop, Result, Zero, Overflow, CarryOut.

## Test plan
- Single request: requester 2 sends ADD, A=5, B=7; `rsp_ready` held high.
  - `req_ready[2]` in T. `rsp_valid[2]` in T+2 with result 12, zero = 0.
- Contention: all four valid continuously with AND ops, `rsp_ready` held high.
  - Grants in order 0, 1, 2, 3, 0, one every 3 cycles.
  - With `ALU_ARB_FIXED_PRIO_EN` defined, requester 0 wins every time.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP.
  - `rsp_valid` and the data stay stable, `req_ready` stays 0, and requester 1 waits.
- SUB/SLT flags:
  - SUB 0x80000000 − 1 gives 0x7FFFFFFF with overflow = 1.
  - SLT A=0xFFFFFFFF, B=1 gives 1.
  - SUB 3 − 3 gives 0 with zero = 1.
- Reset mid-RESP: assert `rst` while `rsp_valid[0]` is high.
  - All outputs go to 0 at once. The next request is granted to requester 0.
- Illegal op 011: result 0, `rsp_zero` = 1, and the handshake completes normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants, ALU opcode and arbiter FSM encodings, and the ID-to-one-hot
// helper used by the alu_arbiter slice.
package alu_arb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int OP_W       = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: request handshake with packed
// operands, tagged response bus and status.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]       req_op;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_result;
    logic                          rsp_zero;
    logic                          rsp_overflow;
    logic                          rsp_carryout;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
               rsp_carryout, grant_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
               rsp_carryout, grant_id, busy
    );

endinterface

// File: rtl/alu.sv
// Shared combinational 32-bit ALU: AND/OR/ADD/SUB/SLT; unknown opcodes give 0.
// SUB and SLT reuse the adder as A + ~B + 1, so CarryOut means "no borrow".
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [OP_W-1:0]       ALUop,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  Overflow,
    output logic                  CarryOut
);

    logic                  sub;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   sum;
    logic                  add_ovf;

    always_comb begin
        sub     = (ALUop == OP_SUB) || (ALUop == OP_SLT);
        b_eff   = sub ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
        add_ovf = (A[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            OP_AND: Result = A & B;
            OP_OR:  Result = A | B;
            OP_ADD, OP_SUB: begin
                Result   = sum[DATA_WIDTH-1:0];
                Overflow = add_ovf;
                CarryOut = sum[DATA_WIDTH];
            end
            // signed less-than: sign of the difference corrected by overflow
            OP_SLT: Result = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ add_ovf};
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational requester picker: round-robin starting after last_grant, or
// fixed priority 0 > 1 > 2 > 3 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_pick
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // scan high to low so the lowest valid index is written last
    always_comb begin
        grant_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ID_W'(i)]) grant_id = ID_W'(i);
        end
    end
`else
    // offset NUM_REQ wraps to last_grant itself, so it has the lowest priority
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_id = '0;
        cand     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last_grant + ID_W'(k);
            if (req_valid[cand]) grant_id = cand;
        end
    end
`endif

    assign grant = (|req_valid) ? id_onehot(grant_id) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among four requesters: pick and latch operands, execute,
// then hold a tagged response. Picker policy follows ALU_ARB_FIXED_PRIO_EN.
//
// state   | meaning
// IDLE    | waiting for any req_valid; req_ready asserted for the winner
// EXEC    | ALU evaluates latched operands; result captured at cycle end
// RESP    | rsp_valid[grant_id] held until rsp_ready[grant_id]
module alu_arbiter
    import alu_arb_pkg::*;
(
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  rsp_overflow_q, rsp_overflow_d;
    logic                  rsp_carryout_q, rsp_carryout_d;

    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [ID_W-1:0]       pick_id;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  alu_carryout;

    alu_rr_pick u_pick (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_id   (pick_id)
    );

    alu u_alu (
        .A        (a_q),
        .B        (b_q),
        .ALUop    (op_q),
        .Result   (alu_result),
        .Zero     (alu_zero),
        .Overflow (alu_overflow),
        .CarryOut (alu_carryout)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_carryout_d = rsp_carryout_q;
        req_ready      = '0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    req_ready    = pick_grant;
                    a_d          = DATA_WIDTH'(bus.req_a >> (DATA_WIDTH * 32'(pick_id)));
                    b_d          = DATA_WIDTH'(bus.req_b >> (DATA_WIDTH * 32'(pick_id)));
                    op_d         = OP_W'(bus.req_op >> (OP_W * 32'(pick_id)));
                    grant_id_d   = pick_id;
                    last_grant_d = pick_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d   = alu_result;
                rsp_zero_d     = alu_zero;
                rsp_overflow_d = alu_overflow;
                rsp_carryout_d = alu_carryout;
                rsp_valid_d    = id_onehot(grant_id_q);
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready[grant_id_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
            grant_id_q     <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            rsp_valid_q    <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_carryout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_id_q     <= grant_id_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_carryout_q <= rsp_carryout_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_carryout = rsp_carryout_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, contention,
// backpressure, reset mid-response and randomized traffic against a model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        v;
        logic        c;
    } alu_out_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        alu_out_t    exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus();
    alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  model_last;
    logic [31:0] opa [4];
    logic [31:0] opb [4];
    logic [2:0]  opc [4];
    vec_t        vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Reference ALU from signed/unsigned integer arithmetic.
    function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
        alu_out_t o;
        longint   sa, sb, s;
        o  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: o.res = a & b;
            3'b001: o.res = a | b;
            3'b010: begin
                s     = sa + sb;
                o.res = 32'(s);
                o.v   = (s != longint'($signed(o.res)));
                o.c   = ((64'(a) + 64'(b)) >> 32) != 64'd0;
            end
            3'b110: begin
                s     = sa - sb;
                o.res = 32'(s);
                o.v   = (s != longint'($signed(o.res)));
                o.c   = (a >= b);
            end
            3'b111: o.res = (sa < sb) ? 32'd1 : 32'd0;
            default: o.res = 32'd0;
        endcase
        o.z = (o.res == 32'd0);
        return o;
    endfunction

    function automatic logic [1:0] pick_ref(input logic [3:0] v, input logic [1:0] last);
        logic [1:0] idx;
        idx = last;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[2'(i)]) return 2'(i);
`else
        for (int k = 1; k <= 4; k++) begin
            idx = 2'((int'(last) + k) % 4);
            if (v[idx]) return idx;
        end
`endif
        return idx;
    endfunction

    task automatic drive_ops();
        logic [127:0] va, vb;
        logic [11:0]  vo;
        va = '0;
        vb = '0;
        vo = '0;
        for (int i = 0; i < 4; i++) begin
            va |= 128'(opa[2'(i)]) << (32 * i);
            vb |= 128'(opb[2'(i)]) << (32 * i);
            vo |= 12'(opc[2'(i)]) << (3 * i);
        end
        bus.req_a  = va;
        bus.req_b  = vb;
        bus.req_op = vo;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        tick();
        rst        = 1'b0;
        model_last = 2'd3;
    endtask

    // One isolated operation, rsp_ready held high: accept T, EXEC T+1, RESP T+2.
    task automatic single_txn(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            opa[2'(i)] = $urandom;
            opb[2'(i)] = $urandom;
            opc[2'(i)] = 3'($urandom_range(0, 7));
        end
        opa[v.id] = v.a;
        opb[v.id] = v.b;
        opc[v.id] = v.op;
        drive_ops();
        bus.req_valid = oh(v.id);
        bus.rsp_ready = 4'hF;
        #1;
        chk("vec_req_ready", 64'(bus.req_ready), 64'(oh(v.id)));
        chk("vec_idle_busy", 64'(bus.busy), 64'd0);
        tick();
        bus.req_valid = '0;
        #1;
        chk("vec_exec_busy", 64'(bus.busy), 64'd1);
        chk("vec_exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        #1;
        chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'(oh(v.id)));
        chk("vec_grant_id", 64'(bus.grant_id), 64'(v.id));
        chk("vec_result", 64'(bus.rsp_result), 64'(v.exp.res));
        chk("vec_zero", 64'(bus.rsp_zero), 64'(v.exp.z));
        chk("vec_overflow", 64'(bus.rsp_overflow), 64'(v.exp.v));
        chk("vec_carryout", 64'(bus.rsp_carryout), 64'(v.exp.c));
        tick();
        #1;
        chk("vec_done_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("vec_done_busy", 64'(bus.busy), 64'd0);
        model_last = v.id;
    endtask

    initial begin
        logic [1:0]  w;
        alu_out_t    e;
        logic [3:0]  pend;
        logic        out_valid;
        logic [1:0]  out_id;
        alu_out_t    out_exp;
        int          t_acc;
        logic [3:0]  exp_ready, exp_rv;
        logic        exp_busy;

        //                id     a              b              op      {res, z v c}
        vecs[0] = '{2'd2, 32'd5,         32'd7,         3'b010, {32'd12,         3'b000}};
        vecs[1] = '{2'd0, 32'h8000_0000, 32'd1,         3'b110, {32'h7FFF_FFFF,  3'b011}};
        vecs[2] = '{2'd1, 32'hFFFF_FFFF, 32'd1,         3'b111, {32'd1,          3'b000}};
        vecs[3] = '{2'd3, 32'd3,         32'd3,         3'b110, {32'd0,          3'b101}};
        vecs[4] = '{2'd0, 32'd5,         32'd9,         3'b011, {32'd0,          3'b100}};
        vecs[5] = '{2'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, {32'h00F0_000F,  3'b000}};
        vecs[6] = '{2'd2, 32'hF000_0000, 32'h0000_000F, 3'b001, {32'hF000_000F,  3'b000}};
        vecs[7] = '{2'd3, 32'hFFFF_FFFF, 32'd1,         3'b010, {32'd0,          3'b101}};
        vecs[8] = '{2'd1, 32'h7FFF_FFFF, 32'd1,         3'b010, {32'h8000_0000,  3'b010}};

        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        model_last    = 2'd3;
        rst           = 1'b1;
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_flags", 64'({bus.rsp_zero, bus.rsp_overflow, bus.rsp_carryout}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) single_txn(vecs[4'(k)]);

        // Contention: all four valid with AND, rsp_ready high; one grant per 3 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opa[2'(i)] = $urandom;
            opb[2'(i)] = $urandom;
            opc[2'(i)] = 3'b000;
        end
        drive_ops();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 4'hF;
        w = 2'd0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (c % 3 == 0) begin
                w = pick_ref(4'hF, model_last);
                model_last = w;
                chk("cont_grant", 64'(bus.req_ready), 64'(oh(w)));
            end else begin
                chk("cont_ready_low", 64'(bus.req_ready), 64'd0);
            end
            if (c % 3 == 2) begin
                chk("cont_rsp_valid", 64'(bus.rsp_valid), 64'(oh(w)));
                chk("cont_result", 64'(bus.rsp_result), 64'(opa[w] & opb[w]));
            end
            tick();
        end
        bus.req_valid = '0;

        // Backpressure: requester 0 held in RESP, requester 1 waits behind it.
        opa[0] = 32'd100;    opb[0] = 32'd23;     opc[0] = 3'b010;
        opa[1] = 32'h1234;   opb[1] = 32'h0234;   opc[1] = 3'b110;
        drive_ops();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 4'b0000;
        #1;
        chk("bp_first_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_exec_ready", 64'(bus.req_ready), 64'd0);
        tick();
        #1;
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("bp_result", 64'(bus.rsp_result), 64'd123);
        bus.rsp_ready = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'h1);
            chk("bp_hold_result", 64'(bus.rsp_result), 64'd123);
            chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 4'b0001;
        tick();
        #1;
        chk("bp_second_grant", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 4'hF;
        tick();
        #1;
        chk("bp_second_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("bp_second_result", 64'(bus.rsp_result), 64'h1000);
        tick();

        // Reset while requester 0's response is pending.
        opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd2; opc[0] = 3'b010;
        drive_ops();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 4'b0000;
        tick();
        bus.req_valid = '0;
        tick();
        #1;
        chk("rmr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("rmr_carry_before", 64'(bus.rsp_carryout), 64'd1);
        rst = 1'b1;
        #1;
        chk("rmr_rsp_valid_async", 64'(bus.rsp_valid), 64'd0);
        chk("rmr_result_async", 64'(bus.rsp_result), 64'd0);
        chk("rmr_flags_async", 64'({bus.rsp_zero, bus.rsp_overflow, bus.rsp_carryout}), 64'd0);
        chk("rmr_busy_async", 64'(bus.busy), 64'd0);
        tick();
        rst        = 1'b0;
        model_last = 2'd3;
        opa[2] = 32'd9; opb[2] = 32'd4; opc[2] = 3'b110;
        drive_ops();
        bus.req_valid = 4'b0101;
        #1;
        chk("rmr_next_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 4'hF;
        tick();
        #1;
        chk("rmr_rsp_result", 64'(bus.rsp_result), 64'd1);
        tick();
        #1;
        w = pick_ref(4'b0100, 2'd0);
        chk("rmr_follow_grant", 64'(bus.req_ready), 64'(oh(w)));
        tick();
        bus.req_valid = '0;
        tick();
        #1;
        chk("rmr_follow_result", 64'(bus.rsp_result), 64'd5);
        tick();
        model_last = w;

        // Randomized traffic against the transaction-level model.
        pend      = '0;
        out_valid = 1'b0;
        out_id    = 2'd0;
        out_exp   = '0;
        t_acc     = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[2'(i)] && $urandom_range(0, 2) == 0) begin
                    pend[2'(i)] = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       opa[2'(i)] = 32'h8000_0000;
                        1:       opa[2'(i)] = 32'($urandom_range(0, 7));
                        default: opa[2'(i)] = $urandom;
                    endcase
                    opb[2'(i)] = ($urandom_range(0, 3) == 0) ? opa[2'(i)] : $urandom;
                    opc[2'(i)] = 3'($urandom_range(0, 7));
                end else if (pend[2'(i)] && $urandom_range(0, 15) == 0) begin
                    pend[2'(i)] = 1'b0;
                end
            end
            drive_ops();
            bus.req_valid = pend;
            bus.rsp_ready = 4'($urandom_range(0, 15));
            #1;
            exp_busy  = out_valid;
            exp_ready = '0;
            w         = 2'd0;
            if (!out_valid && pend != 4'd0) begin
                w         = pick_ref(pend, model_last);
                exp_ready = oh(w);
            end
            exp_rv = (out_valid && cyc >= t_acc + 2) ? oh(out_id) : 4'd0;
            chk("rnd_req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
            chk("rnd_busy", 64'(bus.busy), 64'(exp_busy));
            if (exp_rv != 4'd0) begin
                chk("rnd_grant_id", 64'(bus.grant_id), 64'(out_id));
                chk("rnd_result", 64'(bus.rsp_result), 64'(out_exp.res));
                chk("rnd_flags", 64'({bus.rsp_zero, bus.rsp_overflow, bus.rsp_carryout}),
                    64'({out_exp.z, out_exp.v, out_exp.c}));
                if (bus.rsp_ready[out_id]) out_valid = 1'b0;
            end
            if (exp_ready != 4'd0) begin
                out_valid  = 1'b1;
                out_id     = w;
                t_acc      = cyc;
                out_exp    = alu_ref(opa[w], opb[w], opc[w]);
                pend[w]    = 1'b0;
                model_last = w;
            end
            e = out_exp;
            tick();
        end
        if (e.res === 32'hx) $display("note: last expected result undefined");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
